// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   FRAME_W       width of the packed serial frame (start + data + parity + stops)
//   PAR_*         parity_type codes
//   state_t       transmit controller state encoding
//   parity_en()   true when the parity code inserts a parity bit
//   frame_len()   number of bits in a frame for a given line configuration
package uart_pkg;

    localparam int FRAME_W = 12;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic logic parity_en(input logic [1:0] pt);
        logic en;
        case (pt)
            PAR_ODD, PAR_EVEN:     en = 1'b1;
            PAR_NONE0, PAR_NONE3:  en = 1'b0;
            default:               en = 1'b0;
        endcase
        return en;
    endfunction

    // start + data (7|8) + optional parity + stop (1|2): always 9..12
    function automatic logic [3:0] frame_len(input logic dl, input logic [1:0] pt,
                                             input logic sb);
        return 4'd1 + (dl ? 4'd8 : 4'd7) + (parity_en(pt) ? 4'd1 : 4'd0)
                    + (sb ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_frame_gen.sv
// frame_gen: combinational UART frame packer.
//   rst          in   active-low; when low the output is forced to zero
//   data         in   byte to pack (bit 7 dropped in 7-bit mode)
//   data_length  in   0 = 7 data bits, 1 = 8
//   parity_type  in   parity code, selects whether parity_out is inserted
//   parity_out   in   precomputed parity bit
//   stop_bits    in   0 = one stop bit, 1 = two
//   frame_out    out  frame in the low len bits, start bit at bit len-1,
//                     data MSB first, then parity, then stop bits
module frame_gen
    import uart_pkg::*;
(
    input  logic               rst,
    input  logic [7:0]         data,
    input  logic               data_length,
    input  logic [1:0]         parity_type,
    input  logic               parity_out,
    input  logic               stop_bits,
    output logic [FRAME_W-1:0] frame_out
);

    logic [FRAME_W-1:0] acc;

    // Bits are shifted in in transmission order, so the first bit sent
    // naturally lands at the top of the low len bits.
    always_comb begin
        acc = '0;
        acc = {acc[FRAME_W-2:0], 1'b0};
        for (int i = 7; i >= 0; i--) begin
            if (i != 7 || data_length) begin
                acc = {acc[FRAME_W-2:0], data[i]};
            end
        end
        if (parity_en(parity_type)) begin
            acc = {acc[FRAME_W-2:0], parity_out};
        end
        acc = {acc[FRAME_W-2:0], 1'b1};
        if (stop_bits) begin
            acc = {acc[FRAME_W-2:0], 1'b1};
        end
        frame_out = rst ? acc : '0;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller.
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   tx_valid     in   byte available on tx_data
//   tx_data      in   byte to send
//   tx_ready     out  controller can accept a byte (IDLE)
//   parity_type  in   00/11 none, 01 odd, 10 even
//   stop_bits    in   0 = one stop bit, 1 = two
//   data_length  in   0 = 7 data bits, 1 = 8
//   tx           out  registered serial line, idle high
//   busy         out  frame in progress
//   tx_done      out  one-cycle pulse after the last stop-bit period
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    state_t               state_reg, state_next;
    logic                 accept;

    logic [7:0]           data_reg;
    logic [1:0]           par_reg;
    logic                 stop_reg;
    logic                 dl_reg;

    logic [FRAME_W-1:0]   shift_reg;
    logic [3:0]           bit_cnt_reg;
    logic [BAUD_W-1:0]    baud_cnt_reg;
    logic                 tx_reg;
    logic                 done_reg;

    logic [7:0]           sent_data;
    logic                 parity_bit;
    logic [3:0]           len;
    logic [FRAME_W-1:0]   frame_out;

    // Parity covers only the bits that actually go on the line.
    assign sent_data  = dl_reg ? data_reg : {1'b0, data_reg[6:0]};
    assign parity_bit = (par_reg == PAR_ODD) ? ~^sent_data : ^sent_data;
    assign len        = frame_len(dl_reg, par_reg, stop_reg);

    frame_gen u_frame_gen (
        .rst         (1'b1),
        .data        (data_reg),
        .data_length (dl_reg),
        .parity_type (par_reg),
        .parity_out  (parity_bit),
        .stop_bits   (stop_reg),
        .frame_out   (frame_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // SEND keeps one extra cycle with bit_cnt_reg == 0: tx lags the shift
    // register by one cycle, so that cycle is the tail of the last stop bit.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (tx_valid) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: begin
                if (bit_cnt_reg == 4'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg     <= '0;
            par_reg      <= '0;
            stop_reg     <= 1'b0;
            dl_reg       <= 1'b0;
            shift_reg    <= '1;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_SEND) && (bit_cnt_reg == 4'd0);
            if (accept) begin
                data_reg <= tx_data;
                par_reg  <= parity_type;
                stop_reg <= stop_bits;
                dl_reg   <= data_length;
            end
            case (state_reg)
                ST_LOAD: begin
                    // Left-align so the start bit sits at bit FRAME_W-1.
                    shift_reg    <= frame_out << (4'(FRAME_W) - len);
                    bit_cnt_reg  <= len;
                    baud_cnt_reg <= '0;
                    tx_reg       <= 1'b1;
                end
                ST_SEND: begin
                    if (bit_cnt_reg != 4'd0) begin
                        tx_reg <= shift_reg[FRAME_W-1];
                        if (baud_cnt_reg == BAUD_LAST) begin
                            shift_reg    <= {shift_reg[FRAME_W-2:0], 1'b1};
                            bit_cnt_reg  <= bit_cnt_reg - 4'd1;
                            baud_cnt_reg <= '0;
                        end else begin
                            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                        end
                    end else begin
                        tx_reg <= 1'b1;
                    end
                end
                default: tx_reg <= 1'b1;
            endcase
        end
    end

    assign tx_ready = (state_reg == ST_IDLE);
    assign busy     = (state_reg != ST_IDLE);
    assign tx       = tx_reg;
    assign tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic       data_length = 1'b1;
    logic       tx_ready, tx, busy, tx_done;

    uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .data_length (data_length),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  par;
        logic        stop;
        logic        dl;
        int          len;
        logic [11:0] bits;   // expected frame, first bit at bit len-1
        string       name;
    } vec_t;

    typedef struct {
        logic [11:0] bits;
        int          len;
        int          acc;
        string       name;
    } exp_t;

    vec_t tbl [10];
    vec_t cur;
    exp_t sbq [$];
    int   cyc = 0;
    int   acc_count = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [7:0] d, input logic [1:0] p, input logic s,
                                input logic l, input int n, input logic [11:0] b,
                                input string nm);
        vec_t v;
        v.data = d; v.par = p; v.stop = s; v.dl = l; v.len = n; v.bits = b; v.name = nm;
        return v;
    endfunction

    // Scoreboard producer: every accepted handshake pushes the frame the
    // current stimulus should produce.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst && tx_valid && tx_ready) begin
            e.bits = cur.bits; e.len = cur.len; e.acc = cyc; e.name = cur.name;
            sbq.push_back(e);
            acc_count = acc_count + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        cur         = v;
        tx_data     = v.data;
        parity_type = v.par;
        stop_bits   = v.stop;
        data_length = v.dl;
        tx_valid    = 1'b1;
    endtask

    task automatic wait_accept(input int prev);
        int n = 0;
        while (acc_count == prev && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (acc_count == prev) chk("accept_timeout", 0, 1);
    endtask

    // Consumer: pops one expected frame and checks the line cycle by cycle.
    task automatic check_frame(output int acc);
        exp_t        e;
        int          n;
        int          last;
        bit          ctl_ok;
        logic [11:0] got_bits;
        acc = -1;
        n = 0;
        while (sbq.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() == 0) begin
            chk("frame_timeout", 0, 1);
            return;
        end
        e = sbq.pop_front();
        acc = e.acc;
        n = 0;
        while (cyc < e.acc + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cyc != e.acc + 1) begin
            chk({e.name, " checker_sync"}, cyc, e.acc + 1);
            return;
        end
        ctl_ok   = 1'b1;
        got_bits = e.bits;
        last     = e.acc + 2 + e.len * C;
        for (int k = e.acc + 1; k < last; k++) begin
            if (k > e.acc + 1) @(negedge clk);
            if (tx_ready !== 1'b0 || busy !== 1'b1 || tx_done !== 1'b0) ctl_ok = 1'b0;
            if (k == e.acc + 1 && tx !== 1'b1) ctl_ok = 1'b0;
            if (k >= e.acc + 2) begin
                int j;
                j = (k - e.acc - 2) / C;
                if (tx !== e.bits[e.len-1-j]) got_bits[e.len-1-j] = tx;
            end
        end
        @(negedge clk);
        for (int j = 0; j < e.len; j++) begin
            chk($sformatf("%s bit%0d", e.name, j), 32'(got_bits[e.len-1-j]),
                32'(e.bits[e.len-1-j]));
        end
        chk({e.name, " ready_busy_during_frame"}, 32'(ctl_ok), 1);
        chk({e.name, " done_ready_busy_tx"}, {28'd0, tx_done, tx_ready, busy, tx}, 32'hD);
        $display("frame %s len=%0d accepted@%0d done@%0d", e.name, e.len, e.acc, cyc);
    endtask

    initial begin
        int a1, a2, prev;
        exp_t e;
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, prev, n;
        exp_t e;
        tbl[0] = mk(8'hA5, 2'b00, 1'b0, 1'b1, 10, 12'b0101001011,   "8N1_A5");
        tbl[1] = mk(8'h01, 2'b10, 1'b1, 1'b1, 12, 12'b000000001111, "8E2_01");
        tbl[2] = mk(8'h01, 2'b01, 1'b1, 1'b1, 12, 12'b000000001011, "8O2_01");
        tbl[3] = mk(8'hFF, 2'b00, 1'b0, 1'b0, 9,  12'b011111111,    "7N1_FF");
        tbl[4] = mk(8'hFF, 2'b11, 1'b0, 1'b0, 9,  12'b011111111,    "7N1t3_FF");
        tbl[5] = mk(8'h03, 2'b10, 1'b0, 1'b0, 10, 12'b0000001101,   "7E1_03");
        tbl[6] = mk(8'h80, 2'b01, 1'b1, 1'b0, 11, 12'b00000000111,  "7O2_80");
        tbl[7] = mk(8'h55, 2'b00, 1'b0, 1'b1, 10, 12'b0010101011,   "8N1_55");
        tbl[8] = mk(8'hAA, 2'b00, 1'b0, 1'b1, 10, 12'b0101010101,   "8N1_AA");
        tbl[9] = mk(8'h3C, 2'b00, 1'b0, 1'b1, 10, 12'b0001111001,   "8N1_3C");
        cur = tbl[0];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx_ready_busy_done", {28'd0, tx, tx_ready, busy, tx_done}, 32'hC);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle tx_ready_busy_done", {28'd0, tx, tx_ready, busy, tx_done}, 32'hC);

        // Single frames; inputs scrambled after accept must not matter
        for (int i = 0; i < 10; i++) begin
            if (i == 7 || i == 8) continue;
            prev = acc_count;
            apply(tbl[i]);
            wait_accept(prev);
            tx_valid    = 1'b0;
            tx_data     = 8'($urandom);
            parity_type = 2'($urandom);
            stop_bits   = 1'($urandom);
            data_length = 1'($urandom);
            check_frame(a1);
            chk({tbl[i].name, " single_accept"}, acc_count, prev + 1);
        end

        // Back-to-back with tx_valid held
        prev = acc_count;
        apply(tbl[7]);
        fork
            begin
                wait_accept(prev);
                apply(tbl[8]);
                wait_accept(prev + 1);
                tx_valid = 1'b0;
            end
            begin
                check_frame(a1);
                check_frame(a2);
            end
        join
        chk("b2b accept_spacing", a2 - a1, 3 + 10 * C);
        chk("b2b accept_count", acc_count, prev + 2);

        // Config change mid-frame with tx_valid held: next frame uses new config
        repeat (2) @(negedge clk);
        prev = acc_count;
        apply(tbl[0]);
        fork
            begin
                wait_accept(prev);
                apply(tbl[6]);
                wait_accept(prev + 1);
                tx_valid = 1'b0;
            end
            begin
                check_frame(a1);
                check_frame(a2);
            end
        join
        chk("cfgchg accept_spacing", a2 - a1, 3 + 10 * C);

        // Reset during the 4th data bit (frame bit index 4)
        repeat (2) @(negedge clk);
        prev = acc_count;
        apply(tbl[0]);
        wait_accept(prev);
        tx_valid = 1'b0;
        e = sbq.pop_front();
        n = 0;
        while (cyc < e.acc + 2 + 4 * C + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst pre_tx_data_bit", 32'(tx), 32'(e.bits[e.len-1-4]));
        #2 rst = 1'b0;
        #1;
        chk("rst async tx_ready_busy_done", {28'd0, tx, tx_ready, busy, tx_done}, 32'hC);
        repeat (2) @(negedge clk);
        chk("rst held tx_ready_busy_done", {28'd0, tx, tx_ready, busy, tx_done}, 32'hC);
        rst = 1'b1;
        sbq.delete();
        repeat (C * 12) @(negedge clk);
        chk("post_rst line_idle", {28'd0, tx, tx_ready, busy, tx_done}, 32'hC);
        prev = acc_count;
        apply(tbl[9]);
        wait_accept(prev);
        tx_valid = 1'b0;
        check_frame(a1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side controller for the UART: accepts a byte over a valid/ready handshake, latches the line configuration, computes parity, drives the combinational `frame_gen` packer, and serializes the resulting 9–12-bit frame onto `tx` at a parameterized bit rate. It sits between the host-side byte source and the serial pin, and is the only sequencer of `frame_gen`.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (≥2); 868 = 100 MHz / 115200.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  byte available on `tx_data`.
- `tx_data`  in  8  byte to send; with 7-bit mode only `[6:0]` is sent.
- `tx_ready`  out  1  controller can accept; reset 1.
- `parity_type`  in  2  00 none, 01 odd, 10 even, 11 none.
- `stop_bits`  in  1  0 = one stop bit, 1 = two.
- `data_length`  in  1  0 = 7 data bits, 1 = 8.
- `tx`  out  1  serial line, idle high; reset 1.
- `busy`  out  1  frame in progress (LOAD or SEND); reset 0.
- `tx_done`  out  1  one-cycle pulse after the last bit period; reset 0.

## Operation
- States: IDLE, LOAD, SEND.
- IDLE: `tx`=1, `tx_ready`=1. On `tx_valid && tx_ready`, register `tx_data`, `parity_type`, `stop_bits`, `data_length`, go to LOAD.
- Config is sampled only at accept; input changes during LOAD/SEND are ignored.
- Parity over the sent data bits only (7 or 8): odd → bit makes the total count of ones odd; even → total even. Passed to `frame_gen` as `parity_out`; ignored by it for types 00/11.
- Frame length `len` = 1 + (7|8) + (1 if type 01/10) + (1|2), range 9..12.
- `frame_gen` places the frame in the low `len` bits of its 12-bit output, start bit at the highest of those, data MSB first, then parity, then stop bits.
- LOAD (1 cycle): shift register ← `frame_out << (12 − len)`; bit counter ← `len`; baud counter ← 0; go to SEND.
- SEND: `tx` = shift register bit 11. Baud counter counts 0..CLKS_PER_BIT−1. At the terminal count, shift left by 1, decrement the bit counter, and clear the baud counter. When the bit counter reaches 0, pulse `tx_done` and return to IDLE.
- `tx` is registered. No glitches between bits.
- Reset at any time, including mid-frame: immediately `tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0, state IDLE. The partial frame is abandoned and not resumed.

## Timing
- Accept at edge N. LOAD during cycle N+1. Start bit drives `tx` from edge N+2.
- Each bit is held exactly CLKS_PER_BIT cycles.
- `tx_done` is high for the single cycle after the last stop-bit period. `tx_ready` rises in that same cycle.
- Accept-to-done is 1 + len·CLKS_PER_BIT + 1 cycles.
- Back-to-back: a byte presented with `tx_valid` held is accepted on the `tx_done` cycle. The line stays high for that one cycle between frames.
- `tx_ready` is low throughout LOAD and SEND. `tx_valid` during that time is not consumed.

## Structure
- Shared package `uart_pkg`: parity codes (PAR_NONE0=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE3=11), state encoding, `FRAME_W`=12, and a function for `len`.
- Sub-module: the existing `frame_gen`, instantiated with its `rst` tied inactive and fed from the latched registers.
- Baud counter width: $clog2(CLKS_PER_BIT). Bit counter: 4 bits.

## Test plan
Run with `CLKS_PER_BIT`=4.
- 8N1, byte 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `tx_done` 42 cycles after accept.
- 8E2, byte 0x01 → 0,0000000 1,parity 1,1,1 (12 bits); with odd parity the same byte gives parity 0.
- 7N1, byte 0xFF → 0,1111111,1 (9 bits); bit 7 is never sent. Type 11 gives the same result as type 00.
- Hold `tx_valid` with 0x55 then 0xAA → two frames, exactly one idle-high cycle between them. `tx_ready`=0 throughout each frame.
- Change `data_length`/`parity_type` mid-frame → current frame unaffected; next frame uses the new values.
- Assert `rst` low during the 4th data bit → `tx`=1 and `tx_ready`=1 asynchronously. After release, a new 0x3C frame is sent correctly.
